v_vsampler_frame_ctrl: RTL

//  Frame sequencer in front of the v_vsampler datapath, on the AXI4-Stream video path.
//  Per frame it does three things:
//  - latches the frame size;
//  - aligns the stream to SOF (TUSER);
//  - enforces line length (TLAST) and frame length.
//  It drives hsize/vsize to the sampler, reports done/idle and flags framing errors.

---
 rtl/v_vsampler_pkg.sv | 9 +
 rtl/v_vsampler_axis_slice.sv | 23 ++
 rtl/v_vsampler_frame_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/v_vsampler_pkg.sv
// v_vsampler_pkg: shared FSM states, err_status bit indices and counter width for the v_vsampler path
package v_vsampler_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int ERR_EARLY_EOL = 0;
  localparam int ERR_LATE_EOL = 1;
  localparam int ERR_SOF = 2;
  localparam int ERR_CFG = 3;
  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DRAIN} state_t;
endpackage

// File: rtl/v_vsampler_axis_slice.sv
// v_vsampler_axis_slice: one-deep valid/ready register slice, payload held while stalled
module v_vsampler_axis_slice #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
endmodule

// File: rtl/v_vsampler_frame_ctrl.sv
// v_vsampler_frame_ctrl: AXI4-Stream frame sequencer (SOF align, line/frame length enforcement).
// Optional saturating err_count output when V_VSAMPLER_FRAME_CTRL_ERRCNT_EN is defined.
module v_vsampler_frame_ctrl
  import v_vsampler_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int MAX_COLS = 1280,
  parameter int MAX_ROWS = 720,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [CNT_W-1:0]      cfg_hsize,
  input  logic [CNT_W-1:0]      cfg_vsize,
  output logic [CNT_W-1:0]      hsize_out,
  output logic [CNT_W-1:0]      vsize_out,
  input  logic [DATA_WIDTH-1:0] s_axis_TDATA,
  input  logic                  s_axis_TVALID,
  output logic                  s_axis_TREADY,
  input  logic                  s_axis_TUSER,
  input  logic                  s_axis_TLAST,
  output logic [DATA_WIDTH-1:0] m_axis_TDATA,
  output logic                  m_axis_TVALID,
  input  logic                  m_axis_TREADY,
  output logic                  m_axis_TUSER,
  output logic                  m_axis_TLAST,
`ifdef V_VSAMPLER_FRAME_CTRL_ERRCNT_EN
  output logic [15:0]           err_count,
`endif
  output logic [3:0]            err_status
);
  state_t state, state_nx;
  logic [CNT_W-1:0] col, row, col_nx, row_nx, ccol, crow;
  logic [3:0] err_ev;
  logic acc, fwd, sof, at_end, eol, last_row, cfg_bad, reload, load, start_q, rise;
  logic sl_ready, m_eof;
  assign acc = s_axis_TVALID && s_axis_TREADY;
  assign fwd = acc && (state == ACTIVE || (state == WAIT_SOF && s_axis_TUSER));
  assign sof = s_axis_TUSER && state != DRAIN;
  assign ccol = sof ? '0 : col;
  assign crow = sof ? '0 : row;
  assign at_end = ccol == hsize_out - CNT_W'(1);
  assign eol = at_end || s_axis_TLAST;
  assign last_row = crow == vsize_out - CNT_W'(1);
  assign cfg_bad = cfg_hsize == '0 || cfg_vsize == '0 ||
                   cfg_hsize > CNT_W'(MAX_COLS) || cfg_vsize > CNT_W'(MAX_ROWS);
  assign rise = ap_start && !start_q;
  assign ap_idle = state == IDLE;
  assign s_axis_TREADY = state != IDLE && sl_ready;
  always_comb begin
    state_nx = state;
    col_nx = col;
    row_nx = row;
    err_ev = '0;
    reload = 1'b0;
    load = 1'b0;
    case (state)
      IDLE: reload = 1'b1;
      WAIT_SOF, ACTIVE: if (fwd) begin
        err_ev[ERR_SOF] = state == ACTIVE && s_axis_TUSER && (col != '0 || row != '0);
        err_ev[ERR_EARLY_EOL] = s_axis_TLAST && !at_end;
        err_ev[ERR_LATE_EOL] = at_end && !s_axis_TLAST;
        col_nx = eol ? '0 : ccol + CNT_W'(1);
        row_nx = eol ? crow + CNT_W'(1) : crow;
        state_nx = err_ev[ERR_LATE_EOL] ? DRAIN : ACTIVE;
        reload = eol && last_row && !err_ev[ERR_LATE_EOL];
      end
      default: if (acc && s_axis_TLAST) begin
        state_nx = ACTIVE;
        reload = row == vsize_out;
      end
    endcase
    // frame boundary (or idle): restart only with a legal size pair
    if (reload) begin
      load = ap_start;
      err_ev[ERR_CFG] = ap_start && cfg_bad;
      state_nx = (ap_start && !cfg_bad) ? WAIT_SOF : IDLE;
    end
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      hsize_out <= '0;
      vsize_out <= '0;
      err_status <= '0;
      start_q <= 1'b0;
      ap_done <= 1'b0;
    end else begin
      state <= state_nx;
      col <= col_nx;
      row <= row_nx;
      if (load) begin
        hsize_out <= cfg_hsize;
        vsize_out <= cfg_vsize;
      end
      err_status <= (rise ? '0 : err_status) | err_ev;
      start_q <= ap_start;
      ap_done <= m_axis_TVALID && m_axis_TREADY && m_eof;
    end
`ifdef V_VSAMPLER_FRAME_CTRL_ERRCNT_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) err_count <= '0;
    else err_count <= (rise ? '0 : err_count) + 16'(|err_ev && (rise || err_count != '1));
`endif
  // sideband m_eof marks the final beat of a frame so ap_done follows its downstream acceptance
  v_vsampler_axis_slice #(.W(DATA_WIDTH + 3)) u_slice (
    .clk(ap_clk),
    .rst_n(ap_rst_n),
    .in_valid(fwd),
    .in_ready(sl_ready),
    .in_data({eol && last_row, sof, eol, s_axis_TDATA}),
    .out_valid(m_axis_TVALID),
    .out_ready(m_axis_TREADY),
    .out_data({m_eof, m_axis_TUSER, m_axis_TLAST, m_axis_TDATA})
  );
endmodule
